// File: rtl/adc_spi_reader.sv
// SPI master reading one FRAME_BITS frame from the serial ADC; data_valid at SCK_HALF*(1+2*FRAME_BITS) cycles after CS falls.
// No backpressure: start is ignored (not queued) while busy; all outputs registered.
module adc_spi_reader #(
  parameter int SCK_HALF     = 2,
  parameter int FRAME_BITS   = 16,
  parameter int DATA_BITS    = 12,
  parameter int QUIET_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 spi_miso,
  output logic                 spi_cs,
  output logic                 spi_sck,
  output logic                 busy,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  output logic                 frame_err
);

  localparam int CNT_MAX = (SCK_HALF > QUIET_CYCLES) ? SCK_HALF : QUIET_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int BIT_W   = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;
  localparam logic [CNT_W-1:0] HALF_LAST  = CNT_W'(SCK_HALF - 1);
  localparam logic [CNT_W-1:0] QUIET_LAST = CNT_W'(QUIET_CYCLES - 1);
  localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(FRAME_BITS - 1);

  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, STOP} state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [BIT_W-1:0]        bit_q, bit_d;
  logic [FRAME_BITS-1:0]   shift_q, shift_d;
  logic                    cs_q, cs_d;
  logic                    sck_q, sck_d;
  logic                    busy_q, busy_d;
  logic [DATA_BITS-1:0]    data_q, data_d;
  logic                    valid_q, valid_d;
  logic                    err_q, err_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      cs_q    <= 1'b1;
      sck_q   <= 1'b1;
      busy_q  <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      cs_q    <= cs_d;
      sck_q   <= sck_d;
      busy_q  <= busy_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    cs_d    = cs_q;
    sck_d   = sck_q;
    busy_d  = busy_q;
    data_d  = data_q;
    valid_d = 1'b0;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SETUP;
          cs_d    = 1'b0;
          busy_d  = 1'b1;
          cnt_d   = '0;
        end
      end
      SETUP: begin
        if (cnt_q == HALF_LAST) begin
          state_d = SHIFT;
          sck_d   = 1'b0;
          cnt_d   = '0;
          bit_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      SHIFT: begin
        // sck_q itself tells which half of the SCK period is running
        if (cnt_q != HALF_LAST) begin
          cnt_d = cnt_q + 1'b1;
        end else if (!sck_q) begin
          cnt_d   = '0;
          sck_d   = 1'b1;
          shift_d = {shift_q[FRAME_BITS-2:0], spi_miso};
        end else if (bit_q == BIT_LAST) begin
          state_d = STOP;
          cnt_d   = '0;
          cs_d    = 1'b1;
          data_d  = shift_q[DATA_BITS-1:0];
          err_d   = |shift_q[FRAME_BITS-1:DATA_BITS];
          valid_d = 1'b1;
        end else begin
          cnt_d = '0;
          bit_d = bit_q + 1'b1;
          sck_d = 1'b0;
        end
      end
      STOP: begin
        if (cnt_q == QUIET_LAST) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign spi_cs     = cs_q;
  assign spi_sck    = sck_q;
  assign busy       = busy_q;
  assign data_out   = data_q;
  assign data_valid = valid_q;
  assign frame_err  = err_q;

endmodule

// File: tb/tb_adc_spi_reader.sv
// Bench for adc_spi_reader: default instance (d=0) and a SCK_HALF=1/QUIET_CYCLES=1 instance (d=1),
// each fed by a frame-level ADC model; frame timing and payload checked against spec arithmetic.
module tb_adc_spi_reader;

  localparam int FB  = 16;
  localparam int DB  = 12;
  localparam int SH0 = 2;
  localparam int Q0  = 4;
  localparam int SH1 = 1;
  localparam int Q1  = 1;

  logic clk, rst;
  logic [1:0] start;
  logic [1:0] miso;
  logic [1:0] cs, sck, busy, vld, err;
  logic [1:0][DB-1:0] dout;

  int tests, fails;

  adc_spi_reader #(.SCK_HALF(SH0), .FRAME_BITS(FB), .DATA_BITS(DB), .QUIET_CYCLES(Q0)) u_dut0 (
    .clk(clk), .rst(rst), .start(start[0]), .spi_miso(miso[0]),
    .spi_cs(cs[0]), .spi_sck(sck[0]), .busy(busy[0]),
    .data_out(dout[0]), .data_valid(vld[0]), .frame_err(err[0]));

  adc_spi_reader #(.SCK_HALF(SH1), .FRAME_BITS(FB), .DATA_BITS(DB), .QUIET_CYCLES(Q1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start[1]), .spi_miso(miso[1]),
    .spi_cs(cs[1]), .spi_sck(sck[1]), .busy(busy[1]),
    .data_out(dout[1]), .data_valid(vld[1]), .frame_err(err[1]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected frame timing straight from the protocol description
  int exp_lat [2];
  int exp_busy[2];
  initial begin
    exp_lat[0]  = SH0 + FB * 2 * SH0;
    exp_lat[1]  = SH1 + FB * 2 * SH1;
    exp_busy[0] = exp_lat[0] + Q0;
    exp_busy[1] = exp_lat[1] + Q1;
  end

  // ADC model + bus monitor, sampled on the falling clk edge
  logic [15:0] adc_word[2];
  logic [15:0] cur_word[2];
  int cyc;
  int adc_bit[2], rise_cnt[2], fall_cnt[2], vld_cnt[2], viol[2];
  int cs_fall_cyc[2], cs_rise_cyc[2], cs_gap[2], last_vld_cyc[2], vld_gap[2], lat[2], busy_len[2];
  logic [1:0] prev_cs, prev_sck, prev_busy;

  initial begin
    cyc = 0;
    for (int d = 0; d < 2; d++) begin
      adc_bit[d] = 0; rise_cnt[d] = 0; fall_cnt[d] = 0; vld_cnt[d] = 0; viol[d] = 0;
      cs_fall_cyc[d] = 0; cs_rise_cyc[d] = 0; cs_gap[d] = 0; last_vld_cyc[d] = 0;
      vld_gap[d] = 0; lat[d] = 0; busy_len[d] = 0; cur_word[d] = '0;
    end
    prev_cs = 2'b11; prev_sck = 2'b11; prev_busy = 2'b00; miso = 2'b00;
  end

  always @(negedge clk) begin
    cyc++;
    for (int d = 0; d < 2; d++) begin
      if (prev_cs[d] && !cs[d]) begin
        cs_fall_cyc[d] = cyc;
        cs_gap[d]      = cyc - cs_rise_cyc[d];
        rise_cnt[d] = 0; fall_cnt[d] = 0; vld_cnt[d] = 0; adc_bit[d] = 0;
        cur_word[d] = adc_word[d];
      end
      if (!prev_cs[d] && cs[d]) cs_rise_cyc[d] = cyc;
      if (!cs[d] && prev_sck[d] && !sck[d]) begin
        fall_cnt[d]++;
        if (adc_bit[d] < FB) miso[d] = cur_word[d][FB-1-adc_bit[d]];
        adc_bit[d]++;
      end
      if (!cs[d] && !prev_sck[d] && sck[d]) rise_cnt[d]++;
      if (cs[d] && !sck[d]) viol[d]++;
      if (vld[d]) begin
        vld_cnt[d]++;
        vld_gap[d]      = cyc - last_vld_cyc[d];
        last_vld_cyc[d] = cyc;
        lat[d]          = cyc - cs_fall_cyc[d];
      end
      if (busy[d] && !prev_busy[d]) busy_len[d] = 0;
      if (busy[d]) busy_len[d]++;
    end
    prev_cs = cs; prev_sck = sck; prev_busy = busy;
  end

  task automatic check(input string tag, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_idle(input int d);
    int k = 0;
    @(negedge clk);
    while (busy[d] && k < 400) begin
      @(negedge clk);
      k++;
    end
    check("idle_timeout", int'(busy[d]), 0);
    @(negedge clk);
  endtask

  task automatic pulse_start(input int d);
    @(negedge clk); start[d] = 1'b1;
    @(negedge clk); start[d] = 1'b0;
  endtask

  task automatic run_frame(input int d, input logic [15:0] w, input bit poke);
    adc_word[d] = w;
    pulse_start(d);
    if (poke) begin
      repeat (9) @(negedge clk);
      start[d] = 1'b1; @(negedge clk); start[d] = 1'b0;
      repeat (29) @(negedge clk);
      start[d] = 1'b1; @(negedge clk); start[d] = 1'b0;
    end
    wait_idle(d);
    check("valid_count", vld_cnt[d], 1);
    check("data_out", int'(dout[d]), int'(w[DB-1:0]));
    check("frame_err", int'(err[d]), int'(w[FB-1:DB] != 0));
    check("valid_latency", lat[d], exp_lat[d]);
    check("sck_rises", rise_cnt[d], FB);
    check("sck_falls", fall_cnt[d], FB);
    check("busy_cycles", busy_len[d], exp_busy[d]);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] w;
    int k;
    tests = 0; fails = 0;
    start = 2'b00;
    adc_word[0] = '0; adc_word[1] = '0;
    rst = 1'b1;
    @(negedge clk); start = 2'b11;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check("rst_cs", int'(cs[d]), 1);
      check("rst_sck", int'(sck[d]), 1);
      check("rst_busy", int'(busy[d]), 0);
      check("rst_valid", int'(vld[d]), 0);
      check("rst_data", int'(dout[d]), 0);
      check("rst_err", int'(err[d]), 0);
    end
    start = 2'b00; rst = 1'b0;
    repeat (3) @(negedge clk);

    run_frame(0, 16'h0ABC, 0);
    run_frame(0, 16'hFFFF, 0);
    run_frame(0, 16'h0001, 0);
    run_frame(0, 16'h5A5A, 1);

    for (int i = 0; i < 6; i++) begin
      w = 16'($urandom);
      if (i % 2 == 0) w[15:12] = 4'h0;
      run_frame(0, w, 0);
    end

    // start held high: back-to-back frames
    adc_word[0] = 16'h0123;
    @(negedge clk); start[0] = 1'b1;
    k = 0;
    while (!vld[0] && k < 200) begin @(negedge clk); k++; end
    check("hold_first_valid", int'(vld[0]), 1);
    check("hold_first_data", int'(dout[0]), 'h123);
    adc_word[0] = 16'h0456;
    @(negedge clk);
    k = 0;
    while (!vld[0] && k < 200) begin @(negedge clk); k++; end
    check("hold_second_valid", int'(vld[0]), 1);
    check("hold_second_data", int'(dout[0]), 'h456);
    start[0] = 1'b0;
    @(negedge clk);
    check("hold_valid_gap", vld_gap[0], exp_busy[0] + 1);
    check("hold_cs_gap", cs_gap[0], Q0 + 1);
    wait_idle(0);
    repeat (3) @(negedge clk);
    check("hold_no_third_frame", int'(cs[0]), 1);

    // reset during bit 7 of SHIFT
    run_frame(0, 16'h0ABC, 0);
    adc_word[0] = 16'h0F0F;
    pulse_start(0);
    repeat (31) @(negedge clk);
    check("rst_mid_bits_seen", rise_cnt[0], 7);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_mid_cs", int'(cs[0]), 1);
    check("rst_mid_sck", int'(sck[0]), 1);
    check("rst_mid_busy", int'(busy[0]), 0);
    check("rst_mid_data", int'(dout[0]), 0);
    check("rst_mid_err", int'(err[0]), 0);
    repeat (80) @(negedge clk);
    check("rst_mid_no_valid", vld_cnt[0], 0);
    check("rst_mid_data_held", int'(dout[0]), 0);
    run_frame(0, 16'h0C3F, 0);

    // fast-SCK instance
    run_frame(1, 16'h0ABC, 0);
    run_frame(1, 16'($urandom), 0);
    run_frame(1, 16'h8001, 0);

    for (int d = 0; d < 2; d++) check("sck_low_while_cs_high", viol[d], 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
